// File: rtl/operand_loader.sv
// Operand loader: synchronizes raw switch/button inputs and captures two operands
// on successive button presses for the downstream bitwise logic unit.
module operand_loader #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             operands_valid,
    output logic             waiting_a,
    output logic             waiting_b,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sw_s1;
    logic [WIDTH-1:0] r_sw_s2;
    logic             r_load_s1;
    logic             r_load_s2;
    logic             r_load_prev;
    logic             w_load_edge;

    // Load flops reset high so a button held through reset release never captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_load_s1   <= 1'b1;
            r_load_s2   <= 1'b1;
            r_load_prev <= 1'b1;
        end else begin
            r_sw_s1     <= sw;
            r_sw_s2     <= r_sw_s1;
            r_load_s1   <= load;
            r_load_s2   <= r_load_s1;
            r_load_prev <= r_load_s2;
        end
    end

    assign w_load_edge = r_load_s2 & ~r_load_prev;

    // Load FSM; clear outranks a coincident load edge and spares pair_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= LOAD_A;
            a              <= '0;
            b              <= '0;
            operands_valid <= 1'b0;
            pair_count     <= '0;
        end else if (clear) begin
            r_state        <= LOAD_A;
            a              <= '0;
            b              <= '0;
            operands_valid <= 1'b0;
        end else if (w_load_edge) begin
            case (r_state)
                LOAD_A: begin
                    a       <= r_sw_s2;
                    r_state <= LOAD_B;
                end
                LOAD_B: begin
                    b              <= r_sw_s2;
                    operands_valid <= 1'b1;
                    pair_count     <= pair_count + CNT_W'(1);
                    r_state        <= READY;
                end
                READY: begin
                    a              <= r_sw_s2;
                    operands_valid <= 1'b0;
                    r_state        <= LOAD_B;
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign waiting_a = (r_state == LOAD_A);
    assign waiting_b = (r_state == LOAD_B);

endmodule

// File: doc/operand_loader.md
# operand_loader

Sequential front end for the bitwise logic unit: captures two WIDTH-bit operands from board switches on successive presses of a load button and drives them, held stable, onto the unit's `a` and `b` inputs. Includes a two-flop synchronizer and rising-edge detector on the raw button and switch inputs, a three-state load FSM, an operands-valid flag, and a wrapping count of completed operand pairs. Sits directly upstream of the combinational AND/OR/XOR stage. Its outputs connect to that stage's operand inputs without extra glue.

## Interface
- `WIDTH`, default 4: operand width; must match the downstream logic unit.
- `CNT_W`, default 8: width of `pair_count`.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sw` input WIDTH: raw switch value; asynchronous to `clk`.
- `load` input 1: raw load button, level, asynchronous to `clk`.
- `clear` input 1: synchronous to `clk`; returns the FSM to LOAD_A without touching `pair_count`.
- `a` output WIDTH: operand A to the logic unit.
- `b` output WIDTH: operand B to the logic unit.
- `operands_valid` output 1: high while both `a` and `b` hold a completed pair.
- `waiting_a` output 1: high in state LOAD_A.
- `waiting_b` output 1: high in state LOAD_B.
- `pair_count` output CNT_W: number of completed pairs, modulo 2^CNT_W.

## Operation
- **Synchronizer**
  - `sw` and `load` each pass through two flops: `sw_s1`/`sw_s2` and `load_s1`/`load_s2`.
  - `load_prev` is `load_s2` delayed by one cycle.
  - `load_edge = load_s2 & ~load_prev` (combinational).
- **FSM states:** LOAD_A, LOAD_B, READY.
  - LOAD_A, on `load_edge`: `a <= sw_s2`; go to LOAD_B.
  - LOAD_B, on `load_edge`: `b <= sw_s2`; `operands_valid <= 1`; `pair_count <= pair_count + 1`; go to READY.
  - READY, on `load_edge`: `a <= sw_s2`; `operands_valid <= 0`; `b` keeps its old value; go to LOAD_B.
  - No `load_edge`: state, `a`, `b` and `operands_valid` hold.
- **Decoded outputs:** `waiting_a` and `waiting_b` are decoded directly from the state register, with no extra latency.
- **`pair_count`:** wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- **`clear`:**
  - Sets state to LOAD_A, `a = 0`, `b = 0`, `operands_valid = 0`.
  - Leaves `pair_count` and the synchronizer flops untouched.
- **Priority:** `rst` > `clear` > `load_edge`. A `load_edge` in the same cycle as `clear` is discarded.
- **Held button:** a button held high produces exactly one `load_edge`. Capturing again requires release (`load_s2` low for at least 1 cycle) and a new press.

## Timing
- **Reset values:**
  - State LOAD_A; `a = 0`, `b = 0`, `operands_valid = 0`, `pair_count = 0`.
  - So `waiting_a = 1`, `waiting_b = 0`.
  - `sw_s1` and `sw_s2` reset to 0.
  - `load_s1`, `load_s2` and `load_prev` reset to 1. A button held through reset release causes no capture.
- **Reset mid-operation:** any partially loaded pair is discarded; all outputs take the reset values at the next edge.
- **Load latency:** `load` first sampled high at edge n gives:
  - `load_s1 = 1` after edge n, `load_s2 = 1` after edge n+1;
  - `load_edge` high during the cycle following edge n+1;
  - register update at edge n+2.
  - The updated `a`, `b`, `operands_valid` and `pair_count` are visible after edge n+2.
- **Captured switch value:** the value captured is `sw_s2` at edge n+2, i.e. `sw` as sampled at edge n. `sw` must be stable from edge n-1 through edge n+1.
- **Minimum press spacing:** 4 cycles between rising edges of `load` (release ≥ 2 cycles); closer presses may merge.
- **Output timing:** all outputs are registered or decoded from registers. Downstream combinational results settle within the same cycle.

## Test plan
- **Reset, then normal pair:** reset; `sw = 4'hA`, press; `sw = 4'h6`, press → `a = 4'hA`, `b = 4'h6`, `operands_valid = 1`, `pair_count = 1`; downstream sees AND = 4'h2, OR = 4'hE, XOR = 4'hC.
- **Latency check:** `load` rises just before edge 10 → `a` updates after edge 12, not earlier or later; a second press with `sw = 4'h3` → `b = 4'h3`.
- **Reload from READY:**
  - From READY with `a = 4'hA`, `b = 4'h6`: press with `sw = 4'h1` → `a = 4'h1`, `b = 4'h6`, `operands_valid = 0`, `waiting_b = 1`.
  - Next press with `sw = 4'hF` → `b = 4'hF`, valid.
- **Held button and reset with button held:**
  - `load` held high for 20 cycles → exactly one capture.
  - Assert `rst` while `load` is high, deassert `rst` with `load` still high → no capture until release and re-press.
- **Clear versus load:**
  - Assert `clear` in the cycle `load_edge` is high while in LOAD_B → state LOAD_A, `a = b = 0`, `pair_count` unchanged, no capture.
  - Reset mid-pair (after A is loaded) → `a = 0`, `waiting_a = 1`.
- **Counter wrap:** `CNT_W = 2`; complete 5 pairs → `pair_count` sequence 1, 2, 3, 0, 1.
